gpio_event_controller: RTL and testbench

//  Parametrised GPIO event controller: NUM_CH pins synchronised, optionally debounced, edge/level classified per channel,

---
 rtl/gpio_evt_pkg.sv | 23 ++
 rtl/gpio_event_detector.sv | 71 +++++++
 rtl/gpio_event_controller.sv | 162 ++++++++++++++++
 tb/tb_gpio_event_controller.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_evt_pkg.sv
// Shared types and register map for the GPIO event controller.
package gpio_evt_pkg;

  typedef enum logic [1:0] {
    MODE_RISE  = 2'b00,
    MODE_FALL  = 2'b01,
    MODE_BOTH  = 2'b10,
    MODE_LEVEL = 2'b11
  } mode_e;

  localparam logic [4:0] OFF_EVT_MASK = 5'h00;
  localparam logic [4:0] OFF_DET_MASK = 5'h04;
  localparam logic [4:0] OFF_FLAGS    = 5'h08;
  localparam logic [4:0] OFF_ACTIVE   = 5'h0C;
  localparam logic [4:0] OFF_MODE_LO  = 5'h10;
  localparam logic [4:0] OFF_MODE_HI  = 5'h14;
  localparam logic [4:0] OFF_STATUS   = 5'h18;
  localparam logic [4:0] OFF_CTRL     = 5'h1C;

  localparam int unsigned CTRL_EN_BIT = 0;
  localparam int unsigned CTRL_RR_BIT = 1;

endpackage

// File: rtl/gpio_event_detector.sv
// One channel: 2-flop synchroniser, optional debounce (GPIO_EVT_DEBOUNCE_EN), history flop and
// mode decode into a single-cycle detect.
module gpio_event_detector
  import gpio_evt_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  pin,
  input  mode_e mode,
  input  logic  enable,
  output logic  detect
);

  logic sync1_q, sync2_q, hist_q, filt;
  logic match;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= pin;
      sync2_q <= sync1_q;
      hist_q  <= filt;
    end
  end

`ifdef GPIO_EVT_DEBOUNCE_EN
  logic       filt_q;
  logic [7:0] cnt_q;

  // Filtered level follows the synced level only after DEB_CYCLES consecutive disagreements.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q <= 1'b0;
      cnt_q  <= 8'd0;
    end else if (sync2_q != filt_q) begin
      if (cnt_q == 8'(DEB_CYCLES - 1)) begin
        filt_q <= sync2_q;
        cnt_q  <= 8'd0;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end else begin
      cnt_q <= 8'd0;
    end
  end

  assign filt = filt_q;
`else
  logic unused_deb_cycles;
  assign unused_deb_cycles = ^DEB_CYCLES;
  assign filt = sync2_q;
`endif

  always_comb begin
    match = 1'b0;
    unique case (mode)
      MODE_RISE:  match = filt & ~hist_q;
      MODE_FALL:  match = ~filt & hist_q;
      MODE_BOTH:  match = filt ^ hist_q;
      MODE_LEVEL: match = filt;
      default:    match = 1'b0;
    endcase
    detect = match & enable;
  end

endmodule

// File: rtl/gpio_event_controller.sv
// GPIO event controller: per-channel detectors, pending flags, fixed/round-robin arbitration into
// one active event and a bus register file. Optional debounce via GPIO_EVT_DEBOUNCE_EN.
module gpio_event_controller
  import gpio_evt_pkg::*;
#(
  parameter int unsigned NUM_CH     = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h4010,
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] gpio_in,
  output logic              irq_n,
  input  logic [15:0]       data_bus_write,
  output logic [15:0]       data_bus_read,
  input  logic [31:0]       data_bus_addr,
  input  logic [1:0]        data_bus_mode,
  input  logic              data_bus_select
);

  localparam logic [15:0] CH_MASK   = 16'((32'd1 << NUM_CH) - 32'd1);
  localparam logic [31:0] MODE_MASK = 32'((64'd1 << (2 * NUM_CH)) - 64'd1);
  localparam logic [3:0]  LAST_CH   = 4'(NUM_CH - 1);

  logic [15:0] evt_mask_q, evt_mask_d, det_mask_q, det_mask_d;
  logic [15:0] flags_q, flags_d, active_q, active_d;
  logic [31:0] mode_q, mode_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [3:0]  last_q, last_d;
  logic        irq_q;

  logic [31:0] offset;
  logic        in_range, wr_en, wr_flags, wr_active;
  logic [4:0]  reg_off;

  assign offset    = data_bus_addr - BASE_ADDR;
  assign in_range  = (offset[31:5] == '0) && (offset[1:0] == 2'b00);
  assign reg_off   = offset[4:0];
  assign wr_en     = (data_bus_mode == 2'b10) && data_bus_select && in_range;
  assign wr_flags  = wr_en && (reg_off == OFF_FLAGS);
  assign wr_active = wr_en && (reg_off == OFF_ACTIVE);

  logic [NUM_CH-1:0] detect;
  logic [15:0]       detect_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    gpio_event_detector #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_det (
      .clk   (clk),
      .reset (reset),
      .pin   (gpio_in[i]),
      .mode  (mode_e'(mode_q[2*i +: 2])),
      .enable(det_mask_q[i] & ctrl_q[CTRL_EN_BIT]),
      .detect(detect[i])
    );
  end

  assign detect_w = 16'(detect);

  logic [15:0] merged, pending, grant_oh;
  logic [3:0]  start, grant_idx;
  logic [4:0]  cand;
  logic        grant_found, trigger;

  // A same-edge W1C loses to a new detect; arbitration sees the merged result.
  always_comb begin
    merged      = ((wr_flags ? (flags_q & ~data_bus_write) : flags_q) | detect_w) & CH_MASK;
    pending     = merged & evt_mask_q;
    start       = (ctrl_q[CTRL_RR_BIT] && (last_q != LAST_CH)) ? last_q + 4'd1 : 4'd0;
    grant_found = 1'b0;
    grant_idx   = 4'd0;
    cand        = 5'd0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = 5'(start) + 5'(k);
      if (cand >= 5'(NUM_CH)) cand = cand - 5'(NUM_CH);
      if (!grant_found && pending[cand[3:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[3:0];
      end
    end
    trigger  = (active_q == '0) && !wr_active && grant_found;
    grant_oh = trigger ? (16'd1 << grant_idx) : 16'd0;
  end

  always_comb begin
    evt_mask_d = evt_mask_q;
    det_mask_d = det_mask_q;
    mode_d     = mode_q;
    ctrl_d     = ctrl_q;
    active_d   = active_q;
    last_d     = last_q;
    flags_d    = merged & ~grant_oh;
    if (wr_en) begin
      case (reg_off)
        OFF_EVT_MASK: evt_mask_d = data_bus_write & CH_MASK;
        OFF_DET_MASK: det_mask_d = data_bus_write & CH_MASK;
        OFF_ACTIVE:   active_d = data_bus_write & CH_MASK;
        OFF_MODE_LO:  mode_d[15:0] = data_bus_write & MODE_MASK[15:0];
        OFF_MODE_HI:  mode_d[31:16] = data_bus_write & MODE_MASK[31:16];
        OFF_CTRL:     ctrl_d = data_bus_write[1:0];
        default: ;
      endcase
    end
    if (trigger) begin
      active_d = grant_oh;
      last_d   = grant_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evt_mask_q <= '0;
      det_mask_q <= '0;
      flags_q    <= '0;
      active_q   <= '0;
      mode_q     <= '0;
      ctrl_q     <= '0;
      last_q     <= LAST_CH;
      irq_q      <= 1'b0;
    end else begin
      evt_mask_q <= evt_mask_d;
      det_mask_q <= det_mask_d;
      flags_q    <= flags_d;
      active_q   <= active_d;
      mode_q     <= mode_d;
      ctrl_q     <= ctrl_d;
      last_q     <= last_d;
      irq_q      <= trigger;
    end
  end

  assign irq_n = ~irq_q;

  logic [3:0] act_idx;

  // ACTIVE may hold an arbitrary software value; report its lowest set bit.
  always_comb begin
    act_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (active_q[i]) act_idx = 4'(i);
    end
  end

  always_comb begin
    data_bus_read = 16'h0;
    if (in_range) begin
      case (reg_off)
        OFF_EVT_MASK: data_bus_read = evt_mask_q;
        OFF_DET_MASK: data_bus_read = det_mask_q;
        OFF_FLAGS:    data_bus_read = flags_q;
        OFF_ACTIVE:   data_bus_read = active_q;
        OFF_MODE_LO:  data_bus_read = mode_q[15:0];
        OFF_MODE_HI:  data_bus_read = mode_q[31:16];
        OFF_STATUS:   data_bus_read = {active_q != '0, 11'd0, act_idx};
        OFF_CTRL:     data_bus_read = {14'd0, ctrl_q};
        default:      data_bus_read = 16'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_event_controller.sv
// Bench for gpio_event_controller: register table, directed corner sequences, and random traffic
// against a cycle-level reference model (random part in the non-debounced build).
module tb_gpio_event_controller;

  localparam int unsigned NCH  = 16;
  localparam int unsigned DEB  = 4;
  localparam logic [31:0] BASE = 32'h4010;
`ifdef GPIO_EVT_DEBOUNCE_EN
  localparam int LAT = DEB;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] gpio_in;
  logic [3:0]  gpio_small;
  logic        irq_n, irq_n_small;
  logic [15:0] wdata, rdata, rdata_small;
  logic [31:0] addr;
  logic [1:0]  bmode;
  logic        sel;

  always #5 clk = ~clk;

  gpio_event_controller #(
    .NUM_CH(NCH), .BASE_ADDR(BASE), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset(reset), .gpio_in(gpio_in), .irq_n(irq_n),
    .data_bus_write(wdata), .data_bus_read(rdata), .data_bus_addr(addr),
    .data_bus_mode(bmode), .data_bus_select(sel)
  );

  gpio_event_controller #(
    .NUM_CH(4), .BASE_ADDR(BASE), .DEB_CYCLES(DEB)
  ) dut_small (
    .clk(clk), .reset(reset), .gpio_in(gpio_small), .irq_n(irq_n_small),
    .data_bus_write(wdata), .data_bus_read(rdata_small), .data_bus_addr(addr),
    .data_bus_mode(bmode), .data_bus_select(sel)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [7:0] off, input logic [15:0] d);
    addr  = BASE + 32'(off);
    wdata = d;
    bmode = 2'b10;
    sel   = 1'b1;
    @(posedge clk);
    #1;
    bmode = 2'b00;
    sel   = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] off, output logic [15:0] d, output logic [15:0] ds);
    addr  = BASE + 32'(off);
    bmode = 2'b01;
    sel   = 1'b1;
    #1;
    d     = rdata;
    ds    = rdata_small;
    bmode = 2'b00;
    sel   = 1'b0;
  endtask

  task automatic expect_reg(input string name, input logic [7:0] off, input logic [15:0] exp);
    logic [15:0] d, ds;
    bus_read(off, d, ds);
    check(name, {16'd0, d}, {16'd0, exp});
  endtask

  task automatic do_reset;
    reset      = 1'b0;
    gpio_in    = '0;
    gpio_small = '0;
    bmode      = 2'b00;
    sel        = 1'b0;
    addr       = '0;
    wdata      = '0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  typedef struct {
    logic [7:0]  woff;
    logic [15:0] wd;
    logic [7:0]  roff;
    logic [15:0] exp_main;
    logic [15:0] exp_small;
  } vec_t;

  vec_t tbl[16];

  // Reference model state: registers plus a delay line of pin samples.
  logic [15:0] m_evt, m_det, m_flags, m_active, m_ctrl;
  logic [31:0] m_mode;
  int          m_last;
  logic        m_irq;
  logic [15:0] h0, h1, h2;

  // Flags at edge n come from pin samples n-2 (new) and n-3 (old).
  task automatic model_edge(input logic [15:0] g, input logic we, input logic [7:0] woff,
                            input logic [15:0] wd);
    logic [15:0] det, fl;
    logic        nw, od;
    int          gi, st, c;
    det = '0;
    for (int i = 0; i < 16; i++) begin
      nw = h1[i];
      od = h2[i];
      case (m_mode[2*i +: 2])
        2'd0: det[i] = nw && !od;
        2'd1: det[i] = !nw && od;
        2'd2: det[i] = nw != od;
        default: det[i] = nw;
      endcase
      det[i] = det[i] && m_det[i] && m_ctrl[0];
    end
    fl = ((we && woff == 8'h08) ? (m_flags & ~wd) : m_flags) | det;
    m_irq = (m_active == 0) && !(we && woff == 8'h0C) && ((fl & m_evt) != 0);
    if (m_irq) begin
      st = m_ctrl[1] ? (m_last + 1) % 16 : 0;
      gi = -1;
      for (int k = 0; k < 16; k++) begin
        c = (st + k) % 16;
        if (gi < 0 && fl[c] && m_evt[c]) gi = c;
      end
      m_active = 16'd1 << gi;
      fl[gi]   = 1'b0;
      m_last   = gi;
    end
    m_flags = fl;
    if (we) begin
      case (woff)
        8'h00: m_evt = wd;
        8'h04: m_det = wd;
        8'h0C: m_active = wd;
        8'h10: m_mode[15:0] = wd;
        8'h14: m_mode[31:16] = wd;
        8'h1C: m_ctrl = wd & 16'h3;
        default: ;
      endcase
    end
    h2 = h1;
    h1 = h0;
    h0 = g;
  endtask

  task automatic rnd_step(input logic we, input logic [7:0] woff, input logic [15:0] wd,
                          input logic [15:0] g);
    logic [15:0] d, ds;
    gpio_in = g;
    addr    = BASE + 32'(woff);
    wdata   = wd;
    bmode   = we ? 2'b10 : 2'b00;
    sel     = we;
    model_edge(g, we, woff, wd);
    @(posedge clk);
    #1;
    bmode = 2'b00;
    sel   = 1'b0;
    check("rnd irq_n", {31'd0, irq_n}, {31'd0, !m_irq});
    bus_read(8'h08, d, ds);
    check("rnd FLAGS", {16'd0, d}, {16'd0, m_flags});
    bus_read(8'h0C, d, ds);
    check("rnd ACTIVE", {16'd0, d}, {16'd0, m_active});
  endtask

  initial begin
    logic [15:0] d, ds, g;
    int          r;

    tbl[0]  = '{8'h40, 16'hFFFF, 8'h00, 16'h0000, 16'h0000};
    tbl[1]  = '{8'h40, 16'hFFFF, 8'h04, 16'h0000, 16'h0000};
    tbl[2]  = '{8'h40, 16'hFFFF, 8'h08, 16'h0000, 16'h0000};
    tbl[3]  = '{8'h40, 16'hFFFF, 8'h0C, 16'h0000, 16'h0000};
    tbl[4]  = '{8'h40, 16'hFFFF, 8'h18, 16'h0000, 16'h0000};
    tbl[5]  = '{8'h40, 16'hFFFF, 8'h1C, 16'h0000, 16'h0000};
    tbl[6]  = '{8'h00, 16'hFFFF, 8'h00, 16'hFFFF, 16'h000F};
    tbl[7]  = '{8'h04, 16'hA5A5, 8'h04, 16'hA5A5, 16'h0005};
    tbl[8]  = '{8'h10, 16'hFFFF, 8'h10, 16'hFFFF, 16'h00FF};
    tbl[9]  = '{8'h14, 16'hFFFF, 8'h14, 16'hFFFF, 16'h0000};
    tbl[10] = '{8'h1C, 16'hFFFF, 8'h1C, 16'h0003, 16'h0003};
    tbl[11] = '{8'h18, 16'hFFFF, 8'h18, 16'h0000, 16'h0000};
    tbl[12] = '{8'h0C, 16'h1234, 8'h18, 16'h8002, 16'h8002};
    tbl[13] = '{8'h20, 16'hFFFF, 8'h20, 16'h0000, 16'h0000};
    tbl[14] = '{8'h08, 16'hFFFF, 8'h0C, 16'h1234, 16'h0004};
    tbl[15] = '{8'h40, 16'h0000, 8'h02, 16'h0000, 16'h0000};

    do_reset();
    check("reset irq_n", {31'd0, irq_n}, 32'd1);
    check("reset irq_n small", {31'd0, irq_n_small}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      bus_write(tbl[i].woff, tbl[i].wd);
      bus_read(tbl[i].roff, d, ds);
      check($sformatf("tbl%0d main", i), {16'd0, d}, {16'd0, tbl[i].exp_main});
      check($sformatf("tbl%0d small", i), {16'd0, ds}, {16'd0, tbl[i].exp_small});
    end

    // Basic rising edge: flag at t+2, ACTIVE loads and flag clears on that edge.
    do_reset();
    bus_write(8'h00, 16'h0001);
    bus_write(8'h04, 16'h0001);
    bus_write(8'h10, 16'h0000);
    bus_write(8'h1C, 16'h0001);
    gpio_in[0] = 1'b1;
    tick(1);
    tick(1 + LAT);
    check("t1 irq_n before", {31'd0, irq_n}, 32'd1);
    expect_reg("t1 ACTIVE before", 8'h0C, 16'h0000);
    tick(1);
    check("t1 irq_n low", {31'd0, irq_n}, 32'd0);
    expect_reg("t1 ACTIVE", 8'h0C, 16'h0001);
    expect_reg("t1 FLAGS", 8'h08, 16'h0000);
    expect_reg("t1 STATUS", 8'h18, 16'h8000);
    tick(1);
    check("t1 irq_n release", {31'd0, irq_n}, 32'd1);

    // Fixed priority with ACTIVE busy; rearm write wins over the same-edge trigger.
    do_reset();
    bus_write(8'h00, 16'hFFFF);
    bus_write(8'h04, 16'hFFFF);
    bus_write(8'h1C, 16'h0001);
    gpio_in[7] = 1'b1;
    tick(3 + LAT);
    expect_reg("t2 ACTIVE ch7", 8'h0C, 16'h0080);
    gpio_in[3] = 1'b1;
    gpio_in[5] = 1'b1;
    tick(3 + LAT);
    expect_reg("t2 FLAGS pending", 8'h08, 16'h0028);
    bus_write(8'h0C, 16'h0000);
    expect_reg("t2 ACTIVE rearm edge", 8'h0C, 16'h0000);
    tick(1);
    expect_reg("t2 ACTIVE ch3", 8'h0C, 16'h0008);
    expect_reg("t2 FLAGS left", 8'h08, 16'h0020);
    bus_write(8'h0C, 16'h0000);
    tick(1);
    expect_reg("t2 ACTIVE ch5", 8'h0C, 16'h0020);

    // Round-robin between two level-high channels.
    do_reset();
    bus_write(8'h00, 16'h0003);
    bus_write(8'h04, 16'h0003);
    bus_write(8'h10, 16'h000F);
    bus_write(8'h1C, 16'h0003);
    gpio_in[1:0] = 2'b11;
    tick(3 + LAT);
    expect_reg("t3 first grant", 8'h0C, 16'h0001);
    for (int k = 0; k < 4; k++) begin
      bus_write(8'h0C, 16'h0000);
      tick(1);
      expect_reg($sformatf("t3 rr grant %0d", k), 8'h0C, (k % 2 == 0) ? 16'h0002 : 16'h0001);
    end

    // W1C on the detect edge, bus traffic across an edge, masked flag stays pending.
    do_reset();
    bus_write(8'h04, 16'h0044);
    bus_write(8'h1C, 16'h0001);
    gpio_in[2] = 1'b1;
    tick(2 + LAT);
    bus_write(8'h08, 16'h0004);
    expect_reg("t4 set beats W1C", 8'h08, 16'h0004);
    bus_write(8'h08, 16'h0004);
    expect_reg("t4 W1C clears", 8'h08, 16'h0000);
    gpio_in[6] = 1'b1;
    repeat (4 + LAT) bus_write(8'h00, 16'h0000);
    expect_reg("t4 flag under traffic", 8'h08, 16'h0040);
    check("t4 no irq while masked", {31'd0, irq_n}, 32'd1);
    bus_write(8'h00, 16'h0040);
    tick(1);
    expect_reg("t4 unmask triggers", 8'h0C, 16'h0040);

    // Asynchronous reset while an event is being handled.
    do_reset();
    bus_write(8'h00, 16'h0010);
    bus_write(8'h04, 16'h0010);
    bus_write(8'h1C, 16'h0001);
    gpio_in[4] = 1'b1;
    tick(3 + LAT);
    expect_reg("t6 ACTIVE before reset", 8'h0C, 16'h0010);
    check("t6 irq_n before reset", {31'd0, irq_n}, 32'd0);
    reset = 1'b0;
    #1;
    check("t6 irq_n in reset", {31'd0, irq_n}, 32'd1);
    expect_reg("t6 ACTIVE in reset", 8'h0C, 16'h0000);
    expect_reg("t6 EVT in reset", 8'h00, 16'h0000);
    expect_reg("t6 CTRL in reset", 8'h1C, 16'h0000);
    gpio_in = '0;
    reset   = 1'b1;
    tick(1);

`ifdef GPIO_EVT_DEBOUNCE_EN
    // Debounce window of 4: a 3-cycle glitch is dropped, a 5-cycle pulse flags at t+2+4.
    do_reset();
    bus_write(8'h00, 16'h0001);
    bus_write(8'h04, 16'h0001);
    bus_write(8'h1C, 16'h0001);
    gpio_in[0] = 1'b1;
    tick(3);
    gpio_in[0] = 1'b0;
    tick(12);
    expect_reg("t5 glitch FLAGS", 8'h08, 16'h0000);
    expect_reg("t5 glitch ACTIVE", 8'h0C, 16'h0000);
    gpio_in[0] = 1'b1;
    tick(5);
    gpio_in[0] = 1'b0;
    tick(1);
    expect_reg("t5 ACTIVE at t+5", 8'h0C, 16'h0000);
    tick(1);
    expect_reg("t5 ACTIVE at t+6", 8'h0C, 16'h0001);
    check("t5 irq_n at t+6", {31'd0, irq_n}, 32'd0);
`else
    // Random traffic against the model.
    do_reset();
    m_evt = '0; m_det = '0; m_flags = '0; m_active = '0; m_ctrl = '0; m_mode = '0;
    m_last = 15; m_irq = 1'b0;
    h0 = '0; h1 = '0; h2 = '0;
    g = '0;
    rnd_step(1'b1, 8'h00, 16'hFFFF, g);
    rnd_step(1'b1, 8'h04, 16'hFFFF, g);
    rnd_step(1'b1, 8'h1C, 16'h0001, g);
    for (int n = 0; n < 2500; n++) begin
      g = g ^ 16'($urandom & $urandom & $urandom);
      r = $urandom_range(0, 19);
      case (r)
        0, 1, 2, 3, 4: rnd_step(1'b1, 8'h0C, 16'h0000, g);
        5:  rnd_step(1'b1, 8'h08, 16'($urandom), g);
        6:  rnd_step(1'b1, 8'h00, 16'($urandom) | 16'($urandom), g);
        7:  rnd_step(1'b1, 8'h04, 16'($urandom) | 16'($urandom), g);
        8:  rnd_step(1'b1, 8'h10, 16'($urandom), g);
        9:  rnd_step(1'b1, 8'h14, 16'($urandom), g);
        10: rnd_step(1'b1, 8'h1C, 16'($urandom_range(0, 3)) | 16'($urandom_range(0, 7) != 0), g);
        11: rnd_step(1'b1, 8'h0C, 16'($urandom_range(1, 65535)), g);
        12: rnd_step(1'b1, 8'(4 * $urandom_range(6, 15)), 16'($urandom), g);
        default: rnd_step(1'b0, 8'h40, 16'h0000, g);
      endcase
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
